// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response and macro-side signal bundle for sram_rw_port_ctrl.
// master = upstream requester plus macro model, slave = the controller.
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128,
  parameter int MASK_W = 4
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, resp_ready, sram_rdata,
    input  wr_ready, rd_ready, resp_valid, resp_data,
           sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, resp_ready, sram_rdata,
    output wr_ready, rd_ready, resp_valid, resp_data,
           sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Single-port RW SRAM front end: arbitrates write/read channels onto the
// macro port, captures the 1-cycle-late read data and buffers it in a
// 2-entry response FIFO with valid/ready backpressure.
module sram_rw_port_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128,
  parameter int MASK_W = 4
) (
  input logic               i_clock,
  input logic               i_reset,
  sram_rw_port_ctrl_if.slave bus
);
  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  logic              r_last_gnt;
  logic              r_inflight;
  logic [1:0]        r_cnt;
  logic              r_wptr;
  logic              r_rptr;
  logic [DATA_W-1:0] r_fifo [2];

  logic       w_pop;
  logic [2:0] w_credit;
  logic       w_rd_ok;
  logic       w_wr_req;
  logic       w_rd_req;
  logic       w_conflict;
  logic       w_wr_fire;
  logic       w_rd_fire;

  // A pop frees a slot in the same cycle, so rd_ready may follow resp_ready.
  assign w_pop      = (r_cnt != 2'd0) && bus.resp_ready;
  assign w_credit   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_ok    = (w_credit < 3'd2);

  // Nothing is granted while reset is held.
  assign w_wr_req   = bus.wr_valid && !i_reset;
  assign w_rd_req   = bus.rd_valid && w_rd_ok && !i_reset;
  assign w_conflict = w_wr_req && w_rd_req;

  // On conflict the side not granted last conflict wins; this alternation
  // is what keeps either channel from starving.
  assign w_wr_fire  = w_wr_req && (!w_rd_req || (r_last_gnt == GNT_RD));
  assign w_rd_fire  = w_rd_req && !w_wr_fire;

  assign bus.wr_ready   = w_wr_fire;
  assign bus.rd_ready   = w_rd_fire;
  assign bus.sram_en    = w_wr_fire | w_rd_fire;
  assign bus.sram_wmode = w_wr_fire;
  assign bus.sram_addr  = w_wr_fire ? bus.wr_addr : bus.rd_addr;
  assign bus.sram_wmask = w_wr_fire ? bus.wr_mask : '0;
  assign bus.sram_wdata = w_wr_fire ? bus.wr_data : '0;

  assign bus.resp_valid = (r_cnt != 2'd0);
  assign bus.resp_data  = r_fifo[r_rptr];

  // Control state: arbitration history, read-in-flight flag, FIFO pointers/count.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_gnt <= GNT_RD;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
    end else begin
      if (w_conflict) r_last_gnt <= w_wr_fire ? GNT_WR : GNT_RD;
      r_inflight <= w_rd_fire;
      if (r_inflight) r_wptr <= ~r_wptr;
      if (w_pop)      r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Macro rdata is only valid the cycle after a read issue; capture it then,
  // regardless of what the port is doing in that cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset && r_inflight) r_fifo[r_wptr] <= bus.sram_rdata;
  end
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Bench for sram_rw_port_ctrl: behavioural SRAM macro, directed scenarios
// and a randomized phase, all checked against a transaction-level model.
module tb_sram_rw_port_ctrl;
  localparam int AW = 9;
  localparam int DW = 128;
  localparam int MW = 4;
  localparam int LW = DW / MW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_rw_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  sram_rw_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Behavioural macro: 1-cycle registered read, lane-masked write.
  logic [DW-1:0] sram_mem [2**AW];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) begin
        for (int l = 0; l < MW; l++)
          if (bus.sram_wmask[l]) sram_mem[bus.sram_addr][l*LW +: LW] <= bus.sram_wdata[l*LW +: LW];
      end else begin
        bus.sram_rdata <= sram_mem[bus.sram_addr];
      end
    end
  end

  // Reference model: memory image, queue of accepted reads tagged with the
  // cycle they were accepted, and which side wins the next conflict.
  typedef struct { logic [DW-1:0] d; int c; } ent_t;
  logic [DW-1:0] ref_mem [2**AW];
  ent_t          q[$];
  bit            prefer_wr;
  int            cyc;

  int n_chk = 0;
  int n_err = 0;

  // Observations from the last step, used by directed scenarios.
  bit            s_wf, s_rf, s_pop;
  logic [DW-1:0] s_pdata;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [MW-1:0] wm, input bit rv, input logic [AW-1:0] ra, input bit rr);
    bit ev, epop, ewr, erd, wreq, rreq;
    rst            = r;
    bus.wr_valid   = wv;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.wr_mask    = wm;
    bus.rd_valid   = rv;
    bus.rd_addr    = ra;
    bus.resp_ready = rr;
    #1;
    ev   = (q.size() > 0) && (q[0].c + 2 <= cyc);
    epop = ev && rr;
    wreq = !r && wv;
    rreq = !r && rv && ((q.size() - int'(epop)) < 2);
    ewr  = (wreq && rreq) ? prefer_wr : wreq;
    erd  = rreq && !ewr;
    chk("resp_valid", DW'(bus.resp_valid), DW'(ev));
    if (ev) chk("resp_data", bus.resp_data, q[0].d);
    chk("wr_ready", DW'(bus.wr_ready), DW'(ewr));
    chk("rd_ready", DW'(bus.rd_ready), DW'(erd));
    chk("sram_en", DW'(bus.sram_en), DW'(ewr | erd));
    chk("sram_wmode", DW'(bus.sram_wmode), DW'(ewr));
    if (ewr) begin
      chk("sram_addr_w", DW'(bus.sram_addr), DW'(wa));
      chk("sram_wmask", DW'(bus.sram_wmask), DW'(wm));
      chk("sram_wdata", bus.sram_wdata, wd);
    end else begin
      chk("sram_wmask_idle", DW'(bus.sram_wmask), '0);
      chk("sram_wdata_idle", bus.sram_wdata, '0);
      if (erd) chk("sram_addr_r", DW'(bus.sram_addr), DW'(ra));
    end
    s_wf = bus.wr_ready; s_rf = bus.rd_ready;
    s_pop = bus.resp_valid && rr; s_pdata = bus.resp_data;
    @(posedge clk);
    if (r) begin
      q.delete();
      prefer_wr = 1'b1;
    end else begin
      if (wreq && rreq) prefer_wr = !ewr;
      if (epop) void'(q.pop_front());
      if (ewr)
        for (int l = 0; l < MW; l++)
          if (wm[l]) ref_mem[wa][l*LW +: LW] = wd[l*LW +: LW];
      if (erd) q.push_back('{d: ref_mem[ra], c: cyc});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, rr);
  endtask

  // Pop until the next response appears; an expired bound is a failure.
  task automatic wait_pop(input string tag, output logic [DW-1:0] d);
    bit got = 1'b0;
    d = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      idle(1'b1);
      if (s_pop) begin got = 1'b1; d = s_pdata; end
    end
    chk({tag, "_arrived"}, DW'(got), DW'(1));
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] d, nd, e2, pd;
    int nw, nr, acc, popped;

    for (int i = 0; i < 2**AW; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    q.delete(); prefer_wr = 1'b1; cyc = 0;
    rst = 1'b1;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.rd_valid = 0; bus.rd_addr = '0; bus.resp_ready = 0; bus.sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state with requests pending: nothing granted, nothing valid.
    step(1'b1, 1'b1, 9'h3, rnd(), 4'hF, 1'b1, 9'h4, 1'b1);
    chk("rst_resp_valid", DW'(bus.resp_valid), '0);

    // 1: full write then read-back, response 2 cycles after read fire.
    d = rnd();
    step(1'b0, 1'b1, 9'h1A, d, 4'hF, 1'b0, '0, 1'b1);
    chk("t1_wr_fire", DW'(s_wf), DW'(1));
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h1A, 1'b1);
    chk("t1_rd_fire", DW'(s_rf), DW'(1));
    idle(1'b1);
    chk("t1_not_yet", DW'(s_pop), '0);
    idle(1'b1);
    chk("t1_pop_at_2", DW'(s_pop), DW'(1));
    chk("t1_data", s_pdata, d);

    // 2: partial write over all-ones touches only lane 1.
    step(1'b0, 1'b1, 9'h05, '1, 4'hF, 1'b0, '0, 1'b1);
    nd = rnd();
    step(1'b0, 1'b1, 9'h05, nd, 4'b0010, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h05, 1'b1);
    wait_pop("t2", pd);
    e2 = '1;
    e2[63:32] = nd[63:32];
    chk("t2_data", pd, e2);

    // 3: both channels held high after reset -> W,R,W,R...
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    nw = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 9'(16 + i), rnd(), 4'hF, 1'b1, 9'(i), 1'b1);
      chk("t3_alt", DW'(s_wf), DW'((i % 2) == 0));
      nw += int'(s_wf); nr += int'(s_rf);
    end
    chk("t3_writes", DW'(nw), DW'(4));
    chk("t3_reads", DW'(nr), DW'(4));
    repeat (3) idle(1'b1);

    // 4: backpressure: only 2 reads accepted, then drain in order.
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'(16 + i), 1'b0);
      acc += int'(s_rf);
    end
    chk("t4_accepted", DW'(acc), DW'(2));
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h12, 1'b0);
    chk("t4_stalled", DW'(s_rf), '0);
    popped = 0;
    for (int i = 0; i < 12 && acc < 4; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'(16 + acc), 1'b1);
      acc += int'(s_rf); popped += int'(s_pop);
    end
    chk("t4_rest_accepted", DW'(acc), DW'(4));
    for (int i = 0; i < 12 && q.size() > 0; i++) begin
      idle(1'b1);
      popped += int'(s_pop);
    end
    chk("t4_popped", DW'(popped), DW'(4));

    // 5: read at N, write to same address at N+1 -> old data returned.
    d = ref_mem[9'h40];
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h40, 1'b1);
    step(1'b0, 1'b1, 9'h40, rnd(), 4'hF, 1'b0, '0, 1'b1);
    chk("t5_wr_fire", DW'(s_wf), DW'(1));
    wait_pop("t5", pd);
    chk("t5_data", pd, d);

    // 6: reset with responses buffered and one in flight -> all discarded.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h10, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h11, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h12, 1'b1);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    chk("t6_cleared", DW'(bus.resp_valid), '0);
    popped = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      popped += int'(s_pop);
    end
    chk("t6_no_stale", DW'(popped), '0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 9'h1A, 1'b1);
    wait_pop("t6", pd);
    chk("t6_data", pd, ref_mem[9'h1A]);

    // Randomized traffic on a small address window to force hits.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) == 0, 9'($urandom_range(0, 15)), rnd(), 4'($urandom),
           $urandom_range(0, 1) == 1, 9'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
